// File: rtl/seq_timer_bank.sv
// seq_timer_bank: multi-channel countdown timer bank sharing one free-running prescaler.
// Optional macro SEQ_TIMER_COUNT_OUT_EN adds a count_out readback port.
module seq_timer_bank #(
  parameter int CH    = 4,
  parameter int WIDTH = 16,
  parameter int PRE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CH-1:0]         load,
  input  logic [CH-1:0]         en,
  input  logic [CH*WIDTH-1:0]   data,
  input  logic [CH-1:0]         mode,
  input  logic [PRE_W-1:0]      prescale,
  output logic [CH-1:0]         timeOut,
  output logic [CH-1:0]         expire,
`ifdef SEQ_TIMER_COUNT_OUT_EN
  output logic [CH-1:0]         busy,
  output logic [CH*WIDTH-1:0]   count_out
`else
  output logic [CH-1:0]         busy
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOADED = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_PAUSE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [PRE_W-1:0] pcnt_q;
  logic [PRE_W-1:0] pcnt_d;
  logic             tick;

  // Using >= lets a prescale lowered below the current pcnt wrap on the next edge.
  always_comb begin
    tick   = (pcnt_q >= prescale);
    pcnt_d = tick ? '0 : pcnt_q + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             mode_q;
    logic             mode_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             expire_q;
    logic             expire_d;
    logic [WIDTH-1:0] data_i;

    assign data_i = data[i*WIDTH +: WIDTH];

    always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      mode_d    = mode_q;
      timeout_d = timeout_q;
      expire_d  = 1'b0;

      if (load[i]) begin
        count_d   = data_i;
        reload_d  = data_i;
        mode_d    = mode[i];
        timeout_d = 1'b0;
        state_d   = ST_LOADED;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          ST_LOADED, ST_PAUSE: begin
            if (en[i]) begin
              state_d = ST_RUN;
            end
          end
          ST_RUN: begin
            if (!en[i]) begin
              state_d = ST_PAUSE;
            end else if (tick) begin
              // A load value of 0 is treated like 1: expire on the first tick.
              if (count_q <= WIDTH'(1)) begin
                expire_d  = 1'b1;
                timeout_d = 1'b1;
                if (mode_q) begin
                  count_d = reload_q;
                end else begin
                  count_d = '0;
                  state_d = ST_DONE;
                end
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end
          end
          ST_DONE: begin
            state_d = ST_DONE;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= ST_IDLE;
        count_q   <= '0;
        reload_q  <= '0;
        mode_q    <= 1'b0;
        timeout_q <= 1'b0;
        expire_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        count_q   <= count_d;
        reload_q  <= reload_d;
        mode_q    <= mode_d;
        timeout_q <= timeout_d;
        expire_q  <= expire_d;
      end
    end

    assign timeOut[i] = timeout_q;
    assign expire[i]  = expire_q;
    assign busy[i]    = (state_q == ST_RUN);

`ifdef SEQ_TIMER_COUNT_OUT_EN
    assign count_out[i*WIDTH +: WIDTH] = count_q;
`endif
  end

endmodule

// File: tb/tb_seq_timer_bank.sv
// tb_seq_timer_bank: directed self-checking bench for seq_timer_bank (CH=4, WIDTH=16, PRE_W=8).
module tb_seq_timer_bank;

  localparam int CH    = 4;
  localparam int WIDTH = 16;
  localparam int PRE_W = 8;

  logic                clk;
  logic                reset;
  logic [CH-1:0]       load;
  logic [CH-1:0]       en;
  logic [CH*WIDTH-1:0] data;
  logic [CH-1:0]       mode;
  logic [PRE_W-1:0]    prescale;
  logic [CH-1:0]       timeOut;
  logic [CH-1:0]       expire;
  logic [CH-1:0]       busy;

  int checks;
  int errors;
  int n;

  seq_timer_bank #(.CH(CH), .WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .en       (en),
    .data     (data),
    .mode     (mode),
    .prescale (prescale),
    .timeOut  (timeOut),
    .expire   (expire),
`ifdef SEQ_TIMER_COUNT_OUT_EN
    .busy     (busy),
    .count_out()
`else
    .busy     (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic ld, input logic run,
                               input logic [WIDTH-1:0] value, input logic md);
    load[ch]                = ld;
    en[ch]                  = run;
    data[ch*WIDTH +: WIDTH] = value;
    mode[ch]                = md;
  endtask

  // Returns the number of clocks until the channel's next expire pulse, giving up after 40 clocks.
  task automatic waitExpire(input int ch, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (expire[ch] !== 1'b1 && cnt < 40);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    load     = '0;
    en       = '0;
    data     = '0;
    mode     = '0;
    prescale = '0;

    #50;
    checkOutput("reset timeOut", 32'(timeOut), 32'h0);
    checkOutput("reset expire", 32'(expire), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    #50;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle ignores nothing busy", 32'(busy), 32'h0);

    // Test 1: ch0 one-shot N=5, prescale=0
    $display("[TB] ch0 one-shot N=5");
    applyStimulus(0, 1'b1, 1'b1, 16'd5, 1'b0);
    @(negedge clk);
    checkOutput("t1 loaded not busy", 32'(busy[0]), 32'h0);
    load[0] = 1'b0;
    @(negedge clk);
    checkOutput("t1 run busy", 32'(busy[0]), 32'h1);
    repeat (4) @(negedge clk);
    checkOutput("t1 no early expire", 32'(expire[0]), 32'h0);
    checkOutput("t1 busy before expiry", 32'(busy[0]), 32'h1);
    @(negedge clk);
    checkOutput("t1 expire pulse", 32'(expire[0]), 32'h1);
    checkOutput("t1 timeOut set", 32'(timeOut[0]), 32'h1);
    checkOutput("t1 done not busy", 32'(busy[0]), 32'h0);
    @(negedge clk);
    checkOutput("t1 expire one clock", 32'(expire[0]), 32'h0);
    checkOutput("t1 timeOut sticky", 32'(timeOut[0]), 32'h1);

    // Test 2: pause after two decrements for two edges, resume, then en toggling in DONE
    $display("[TB] ch0 pause/resume");
    applyStimulus(0, 1'b1, 1'b1, 16'd5, 1'b0);
    @(negedge clk);
    checkOutput("t2 load clears timeOut", 32'(timeOut[0]), 32'h0);
    load[0] = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    en[0] = 1'b0;
    @(negedge clk);
    checkOutput("t2 paused not busy", 32'(busy[0]), 32'h0);
    @(negedge clk);
    en[0] = 1'b1;
    @(negedge clk);
    checkOutput("t2 resumed busy", 32'(busy[0]), 32'h1);
    repeat (2) @(negedge clk);
    checkOutput("t2 no early expire", 32'(expire[0]), 32'h0);
    @(negedge clk);
    checkOutput("t2 delayed expire", 32'(expire[0]), 32'h1);
    en[0] = 1'b0;
    @(negedge clk);
    en[0] = 1'b1;
    @(negedge clk);
    checkOutput("t2 done ignores en busy", 32'(busy[0]), 32'h0);
    checkOutput("t2 done ignores en expire", 32'(expire[0]), 32'h0);
    checkOutput("t2 done timeOut held", 32'(timeOut[0]), 32'h1);
    en[0] = 1'b0;

    // Test 3: ch1 auto-reload N=4 at prescale=2, then reload N=2
    $display("[TB] ch1 auto-reload");
    prescale = 8'd2;
    applyStimulus(1, 1'b1, 1'b1, 16'd4, 1'b1);
    @(negedge clk);
    load[1] = 1'b0;
    waitExpire(1, n);
    checkOutput("t3 first expire seen", 32'(expire[1]), 32'h1);
    checkOutput("t3 busy at expiry", 32'(busy[1]), 32'h1);
    waitExpire(1, n);
    checkOutput("t3 period N=4", 32'(n), 32'd12);
    checkOutput("t3 timeOut sticky", 32'(timeOut[1]), 32'h1);
    waitExpire(1, n);
    checkOutput("t3 period N=4 again", 32'(n), 32'd12);
    checkOutput("t3 still busy", 32'(busy[1]), 32'h1);
    repeat (2) @(negedge clk);
    applyStimulus(1, 1'b1, 1'b0, 16'd2, 1'b1);
    @(negedge clk);
    checkOutput("t3 reload clears timeOut", 32'(timeOut[1]), 32'h0);
    checkOutput("t3 reload not busy", 32'(busy[1]), 32'h0);
    load[1] = 1'b0;
    en[1]   = 1'b1;
    waitExpire(1, n);
    checkOutput("t3 expire after reload", 32'(expire[1]), 32'h1);
    waitExpire(1, n);
    checkOutput("t3 period N=2", 32'(n), 32'd6);
    en[1] = 1'b0;

    // Test 4: load on the same edge as ch2 expiry
    $display("[TB] ch2 load vs expiry");
    prescale = 8'd0;
    applyStimulus(2, 1'b1, 1'b1, 16'd1, 1'b0);
    @(negedge clk);
    load[2] = 1'b0;
    @(negedge clk);
    checkOutput("t4 run busy", 32'(busy[2]), 32'h1);
    load[2] = 1'b1;
    @(negedge clk);
    checkOutput("t4 load wins expire", 32'(expire[2]), 32'h0);
    checkOutput("t4 load wins timeOut", 32'(timeOut[2]), 32'h0);
    checkOutput("t4 loaded not busy", 32'(busy[2]), 32'h0);
    load[2] = 1'b0;
    @(negedge clk);
    checkOutput("t4 rerun busy", 32'(busy[2]), 32'h1);
    @(negedge clk);
    checkOutput("t4 expire after rerun", 32'(expire[2]), 32'h1);

    // Test 5: all channels together, then reset mid-run
    $display("[TB] all channels N=3,7,0,1");
    data = {16'd1, 16'd0, 16'd7, 16'd3};
    mode = 4'b0000;
    en   = 4'b1111;
    load = 4'b1111;
    @(negedge clk);
    load = 4'b0000;
    checkOutput("t5 all loaded timeOut", 32'(timeOut), 32'h0);
    @(negedge clk);
    checkOutput("t5 all busy", 32'(busy), 32'hF);
    @(negedge clk);
    checkOutput("t5 N=0/1 expire", 32'(expire), 32'hC);
    checkOutput("t5 busy after first", 32'(busy), 32'h3);
    @(negedge clk);
    checkOutput("t5 quiet clock", 32'(expire), 32'h0);
    @(negedge clk);
    checkOutput("t5 N=3 expire", 32'(expire), 32'h1);
    checkOutput("t5 timeOut mask", 32'(timeOut), 32'hD);
    checkOutput("t5 only ch1 busy", 32'(busy), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5 reset timeOut", 32'(timeOut), 32'h0);
    checkOutput("t5 reset expire", 32'(expire), 32'h0);
    checkOutput("t5 reset busy", 32'(busy), 32'h0);
    repeat (5) @(negedge clk);
    checkOutput("t5 no pulse in reset", 32'(expire), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5 idle after reset busy", 32'(busy), 32'h0);
    checkOutput("t5 idle after reset timeOut", 32'(timeOut), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
